// File: rtl/lcv_mul_acc_pkg.sv
// Shared constants and operand bundle for the shared MAC issue controller.
package lcv_mul_acc_pkg;

  localparam int LCV_MAC_AB_W  = 16;  // multiplicand / multiplier width
  localparam int LCV_MAC_ACC_W = 33;  // addend and result width
  localparam int LCV_MAC_PC_W  = 36;  // internal sum width before truncation

  typedef struct packed {
    logic signed [LCV_MAC_AB_W-1:0]  a;
    logic signed [LCV_MAC_AB_W-1:0]  b;
    logic signed [LCV_MAC_ACC_W-1:0] c;
    logic signed [LCV_MAC_ACC_W-1:0] d;
    logic signed [LCV_MAC_ACC_W-1:0] e;
  } lcv_mac_ops_t;

endpackage

// File: rtl/lcv_rr_picker.sv
// Combinational grant picker: round-robin from last+1 by default,
// lowest-index fixed priority when LCV_MUL_ACC_ARB_FIXED_PRIO_EN is defined.
module lcv_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

`ifdef LCV_MUL_ACC_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scan high-to-low so the last hit is the lowest.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end
`else
  // Rotate the search origin to last+1 and take the first asserted request.
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end
`endif

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// Arbiter + two-stage issue pipeline in front of a shared signed MAC
// computing a*b + c + d + e (wraps modulo 2^33).
// Optional macro: LCV_MUL_ACC_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and removes the round-robin pointer.
module lcv_mul_acc_arb
  import lcv_mul_acc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*LCV_MAC_AB_W-1:0] req_a,
  input  logic [NUM_REQ*LCV_MAC_AB_W-1:0] req_b,
  input  logic [NUM_REQ*LCV_MAC_ACC_W-1:0] req_c,
  input  logic [NUM_REQ*LCV_MAC_ACC_W-1:0] req_d,
  input  logic [NUM_REQ*LCV_MAC_ACC_W-1:0] req_e,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [LCV_MAC_ACC_W-1:0]        res_data,
  output logic [ID_W-1:0]                 res_id
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    last_grant;
  logic               adv;
  logic               xfer;
  lcv_mac_ops_t       ops;
  lcv_mac_ops_t       s1_ops;
  logic               s1_v;
  logic [ID_W-1:0]    s1_id;

  lcv_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (gidx)
  );

  // Whole pipe freezes only when a result is waiting and not taken.
  assign adv       = !(res_valid && !res_ready);
  assign req_ready = rst ? '0 : (grant & {NUM_REQ{adv}});
  assign xfer      = |req_ready;

`ifdef LCV_MUL_ACC_ARB_FIXED_PRIO_EN
  assign last_grant = ID_W'(NUM_REQ-1);
`else
  // Pointer moves only on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= ID_W'(NUM_REQ-1);
    else if (xfer) last_grant <= gidx;
  end
`endif

  // Steer the granted requester's operand slices onto the issue bus.
  always_comb begin
    ops = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ops.a = req_a[LCV_MAC_AB_W*i  +: LCV_MAC_AB_W];
        ops.b = req_b[LCV_MAC_AB_W*i  +: LCV_MAC_AB_W];
        ops.c = req_c[LCV_MAC_ACC_W*i +: LCV_MAC_ACC_W];
        ops.d = req_d[LCV_MAC_ACC_W*i +: LCV_MAC_ACC_W];
        ops.e = req_e[LCV_MAC_ACC_W*i +: LCV_MAC_ACC_W];
      end
    end
  end

  // S1 issue register; a cycle without a transfer becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_id  <= '0;
      s1_ops <= '0;
    end else if (adv) begin
      s1_v   <= xfer;
      s1_id  <= gidx;
      s1_ops <= ops;
    end
  end

  // MAC arithmetic: 32-bit product sign-extended, all sums at 36 bits.
  logic signed [2*LCV_MAC_AB_W-1:0] prod32;
  (* use_dsp = "yes" *) logic signed [LCV_MAC_PC_W-1:0] mac_sum;
  always_comb begin
    prod32  = s1_ops.a * s1_ops.b;
    mac_sum = {{(LCV_MAC_PC_W-2*LCV_MAC_AB_W){prod32[2*LCV_MAC_AB_W-1]}}, prod32}
            + {{(LCV_MAC_PC_W-LCV_MAC_ACC_W){s1_ops.c[LCV_MAC_ACC_W-1]}}, s1_ops.c}
            + {{(LCV_MAC_PC_W-LCV_MAC_ACC_W){s1_ops.d[LCV_MAC_ACC_W-1]}}, s1_ops.d}
            + {{(LCV_MAC_PC_W-LCV_MAC_ACC_W){s1_ops.e[LCV_MAC_ACC_W-1]}}, s1_ops.e};
  end

  // S2 result register; truncation to 33 bits gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (adv) begin
      res_valid <= s1_v;
      res_data  <= mac_sum[LCV_MAC_ACC_W-1:0];
      res_id    <= s1_id;
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// Directed bench for lcv_mul_acc_arb: arithmetic vector table plus
// contention, backpressure, mid-flight reset and sparse-traffic sequences.
module tb_lcv_mul_acc_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*16-1:0]   req_a, req_b;
  logic [N*33-1:0]   req_c, req_d, req_e;
  logic              res_valid;
  logic              res_ready;
  logic [32:0]       res_data;
  logic [IW-1:0]     res_id;

  lcv_mul_acc_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_e(req_e),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setop(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [32:0] c, input logic [32:0] d, input logic [32:0] e);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[33*i +: 33] = c;
    req_d[33*i +: 33] = d;
    req_e[33*i +: 33] = e;
  endtask

  // Drive on the falling edge; checks follow #1 later, far from the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [32:0] c, d, e;
    logic [32:0] exp;
  } vec_t;

  vec_t vec [7];
  int   exp_g [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{16'sd3,      -16'sd4,    33'sd10,        33'sd1,         33'sd2,         33'sd1};
    vec[1] = '{-16'sd32768, -16'sd32768, 33'h0FFFFFFFF,  33'h0FFFFFFFF,  33'h0FFFFFFFF,  33'h13FFFFFFD};
    vec[2] = '{16'sd0,      16'sd0,     33'sd0,         33'sd0,         33'sd0,         33'sd0};
    vec[3] = '{16'sd32767,  16'sd32767, 33'sd0,         33'sd0,         33'sd0,         33'h03FFF0001};
    vec[4] = '{-16'sd32768, 16'sd32767, 33'sd0,         33'sd0,         -33'sd1,        33'h1C0007FFF};
    vec[5] = '{16'sd0,      16'sd0,     33'h100000000,  33'h100000000,  33'h100000000,  33'h100000000};
    vec[6] = '{16'sd100,    -16'sd200,  33'sd5,         -33'sd5,        33'sd7,         -33'sd19993};

    for (int k = 0; k < 8; k++) begin
`ifdef LCV_MUL_ACC_ARB_FIXED_PRIO_EN
      exp_g[k] = 0;
`else
      exp_g[k] = k % N;
`endif
    end

    rst = 1'b1; res_ready = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; req_e = '0;
    for (int i = 0; i < N; i++) setop(i, 16'(i + 1), 16'sd1, 33'sd0, 33'sd0, 33'sd0);
    req_valid = '1;

    // Reset state, with all requesters already asserting valid.
    step(); step(); #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  64'(res_data),  64'd0);
    chk("rst_res_id",    64'(res_id),    64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Contention: all four hold valid for 8 cycles from reset release.
    for (int k = 0; k < 8; k++) begin
      step();
      rst = 1'b0;
      #1;
      chk($sformatf("cont_grant%0d", k), 64'(req_ready), 64'(1 << exp_g[k]));
      if (k >= 2) begin
        chk($sformatf("cont_rv%0d", k),   64'(res_valid), 64'd1);
        chk($sformatf("cont_id%0d", k),   64'(res_id),    64'(exp_g[k-2]));
        chk($sformatf("cont_data%0d", k), 64'(res_data),  64'(exp_g[k-2] + 1));
      end
    end
    step(); req_valid = '0; #1;
    chk("cont_id8", 64'(res_id), 64'(exp_g[6]));
    step(); #1;
    chk("cont_id9", 64'(res_id), 64'(exp_g[7]));
    chk("cont_rv9", 64'(res_valid), 64'd1);
    step(); #1;
    chk("cont_drain", 64'(res_valid), 64'd0);

    // Arithmetic table through requester 0, one op at a time.
    for (int v = 0; v < 7; v++) begin
      step();
      setop(0, vec[v].a, vec[v].b, vec[v].c, vec[v].d, vec[v].e);
      req_valid = 4'b0001;
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'd1);
      step(); req_valid = '0; #1;
      chk($sformatf("vec%0d_lat1", v), 64'(res_valid), 64'd0);
      step(); #1;
      chk($sformatf("vec%0d_valid", v), 64'(res_valid), 64'd1);
      chk($sformatf("vec%0d_data", v),  64'(res_data),  64'(vec[v].exp));
      chk($sformatf("vec%0d_id", v),    64'(res_id),    64'd0);
    end
    step(); #1;
    chk("vec_drain", 64'(res_valid), 64'd0);

    // Backpressure: req1 fills the pipe, then res_ready low for 3 cycles.
    step(); setop(1, 16'sd10, 16'sd1, 33'sd0, 33'sd0, 33'sd0); req_valid = 4'b0010; #1;
    chk("bp_acc10", 64'(req_ready), 64'b0010);
    step(); setop(1, 16'sd11, 16'sd1, 33'sd0, 33'sd0, 33'sd0); #1;
    chk("bp_acc11", 64'(req_ready), 64'b0010);
    step(); setop(1, 16'sd12, 16'sd1, 33'sd0, 33'sd0, 33'sd0); res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step();
      #1;
      chk($sformatf("bp_stall_rdy%0d", s),  64'(req_ready), 64'd0);
      chk($sformatf("bp_stall_rv%0d", s),   64'(res_valid), 64'd1);
      chk($sformatf("bp_stall_data%0d", s), 64'(res_data),  64'd10);
      chk($sformatf("bp_stall_id%0d", s),   64'(res_id),    64'd1);
    end
    step(); res_ready = 1'b1; #1;
    chk("bp_release_rdy",  64'(req_ready), 64'b0010);
    chk("bp_release_data", 64'(res_data),  64'd10);
    step(); req_valid = '0; #1;
    chk("bp_data11", 64'(res_data), 64'd11);
    chk("bp_rv11",   64'(res_valid), 64'd1);
    step(); #1;
    chk("bp_data12", 64'(res_data), 64'd12);
    chk("bp_rv12",   64'(res_valid), 64'd1);
    step(); #1;
    chk("bp_drain", 64'(res_valid), 64'd0);

    // Reset one cycle after two transfers: nothing stale emerges.
    step(); setop(1, 16'sd20, 16'sd1, 33'sd0, 33'sd0, 33'sd0); req_valid = 4'b0010; #1;
    chk("mrst_acc1", 64'(req_ready), 64'b0010);
    step(); setop(2, 16'sd21, 16'sd1, 33'sd0, 33'sd0, 33'sd0); req_valid = 4'b0100; #1;
    chk("mrst_acc2", 64'(req_ready), 64'b0100);
    step(); req_valid = '0; rst = 1'b1; #1;
    chk("mrst_rdy_in_rst", 64'(req_ready), 64'd0);
    step(); rst = 1'b0;
    for (int i = 0; i < N; i++) setop(i, 16'(30 + i), 16'sd1, 33'sd0, 33'sd0, 33'sd0);
    req_valid = 4'b1111; #1;
    chk("mrst_rv_after", 64'(res_valid), 64'd0);
    chk("mrst_grant0",   64'(req_ready), 64'b0001);
    step(); req_valid = '0; #1;
    chk("mrst_no_stale", 64'(res_valid), 64'd0);
    step(); #1;
    chk("mrst_rv_new",   64'(res_valid), 64'd1);
    chk("mrst_id_new",   64'(res_id),    64'd0);
    chk("mrst_data_new", 64'(res_data),  64'd30);
    step(); #1;
    chk("mrst_drain", 64'(res_valid), 64'd0);

    // Sparse: only req2, valid every other cycle.
    for (int k = 0; k < 10; k++) begin
      step();
      req_valid = (k % 2 == 0 && k < 8) ? 4'b0100 : 4'b0000;
      setop(2, 16'(k), 16'sd3, 33'sd0, 33'sd0, 33'sd0);
      #1;
      if (k % 2 == 0 && k < 8)
        chk($sformatf("sp_rdy%0d", k), 64'(req_ready), 64'b0100);
      chk($sformatf("sp_rv%0d", k), 64'(res_valid),
          64'((k >= 2 && k % 2 == 0) ? 1 : 0));
      if (k >= 2 && k % 2 == 0) begin
        chk($sformatf("sp_id%0d", k),   64'(res_id),   64'd2);
        chk($sformatf("sp_data%0d", k), 64'(res_data), 64'(3 * (k - 2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
